// File: rtl/mem_responder_pkg.sv
// Shared constants and pipeline-stage record for the memory responder.
// Modes, the default fault pattern and one stage of the response pipeline.
package mem_responder_pkg;

    localparam logic        MODE_READ          = 1'b0;
    localparam logic        MODE_WRITE         = 1'b1;
    localparam logic [31:0] DEFAULT_FAULT_DATA = 32'hDEADBEEF;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic        is_write;
        logic [31:0] data;
    } stage_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset so data survives a responder reset.
module mem_responder_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  read_en,
    input  logic [3:0]            write_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (write_en[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (read_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one request per cycle in, one response pulse
// per request out LATENCY cycles later, strictly in order.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] FAULT_DATA = DEFAULT_FAULT_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request_enable,
    input  logic        req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        response_enable,
    output logic [31:0] resp_data,
    output logic        err_oob,
    output logic [31:0] err_addr,
    output logic [3:0]  outstanding
);

    // Handshake: request_enable is a single-cycle valid with no ready; every
    // such cycle outside reset is accepted. response_enable is likewise a
    // single-cycle valid that the initiator must take when it appears.

    logic                  accept;
    logic                  oob;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            ram_we;
    logic                  ram_re;
    logic [31:0]           ram_rdata;
    logic [31:0]           held_data;
    logic                  unused_addr_bits;

    stage_t load;
    stage_t pipe [LATENCY];
    stage_t view [LATENCY];

    assign accept           = request_enable && !rst;
    assign word_idx         = req_addr[ADDR_WIDTH+1:2];
    assign oob              = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign ram_re           = accept && !oob && (req_mode == MODE_READ);
    assign ram_we           = (accept && !oob && (req_mode == MODE_WRITE)) ? req_wstrb : 4'b0000;
    assign unused_addr_bits = ^req_addr[1:0];

    mem_responder_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .read_en (ram_re),
        .write_en(ram_we),
        .addr    (word_idx),
        .wdata   (req_wdata),
        .rdata   (ram_rdata)
    );

    always_comb begin
        load          = '0;
        load.valid    = accept;
        load.fault    = oob;
        load.is_write = (req_mode == MODE_WRITE);
        load.data     = oob ? FAULT_DATA : 32'h0;
    end

    // The RAM read register is stage 0, so read data is spliced in there.
    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            view[i] = pipe[i];
        end
        if (pipe[0].valid && !pipe[0].fault && !pipe[0].is_write) begin
            view[0].data = ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
            held_data <= 32'h0;
        end else begin
            pipe[0] <= load;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= view[i-1];
            end
            if (view[LATENCY-1].valid) begin
                held_data <= view[LATENCY-1].data;
            end
        end
    end

    assign response_enable = view[LATENCY-1].valid;
    assign resp_data       = response_enable ? view[LATENCY-1].data : held_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_oob  <= 1'b0;
            err_addr <= 32'h0;
        end else if (accept && oob) begin
            err_oob <= 1'b1;
            if (!err_oob) begin
                err_addr <= req_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= 4'd0;
        end else begin
            case ({accept, response_enable})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default build plus LATENCY=1 and LATENCY=8
// instances sharing the same request stream.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        request_enable;
    logic        req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        resp_en2, resp_en1, resp_en8;
    logic [31:0] resp_data2, resp_data1, resp_data8;
    logic        err_oob2, err_oob1, err_oob8;
    logic [31:0] err_addr2, err_addr1, err_addr8;
    logic [3:0]  outst2, outst1, outst8;

    logic [31:0] exp_q[$];
    logic [31:0] pre [8];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst), .request_enable(request_enable), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .response_enable(resp_en2), .resp_data(resp_data2), .err_oob(err_oob2),
        .err_addr(err_addr2), .outstanding(outst2)
    );

    mem_responder #(.LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .request_enable(request_enable), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .response_enable(resp_en1), .resp_data(resp_data1), .err_oob(err_oob1),
        .err_addr(err_addr1), .outstanding(outst1)
    );

    mem_responder #(.LATENCY(8)) dut_l8 (
        .clk(clk), .rst(rst), .request_enable(request_enable), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .response_enable(resp_en8), .resp_data(resp_data8), .err_oob(err_oob8),
        .err_addr(err_addr8), .outstanding(outst8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive_rd(input logic [31:0] a);
        request_enable = 1'b1;
        req_mode       = MODE_READ;
        req_addr       = a;
        req_wdata      = 32'h0;
        req_wstrb      = 4'h0;
    endtask

    task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        request_enable = 1'b1;
        req_mode       = MODE_WRITE;
        req_addr       = a;
        req_wdata      = d;
        req_wstrb      = s;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        drive_wr(a, d, s);
        tick();
        request_enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic flush();
        request_enable = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    // Issue one read and wait (bounded) for its pulse on the LATENCY=2 instance.
    task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] e);
        int lat;
        drive_rd(a);
        tick();
        request_enable = 1'b0;
        lat = 1;
        while (resp_en2 !== 1'b1 && lat < 16) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_data"}, resp_data2, e);
        tick();
    endtask

    initial begin
        int pulses, first, last, maxo;
        int lat1, lat2, lat8;
        logic [31:0] d1, d2, d8;

        for (int i = 0; i < 8; i++) begin
            pre[i] = 32'hC0DE_0000 ^ (32'h0101_0101 * (i + 1));
        end

        // Reset state
        rst = 1'b1;
        request_enable = 1'b0;
        req_mode = MODE_READ;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        tick();
        tick();
        chk("rst_resp_en", resp_en2, 0);
        chk("rst_resp_data", resp_data2, 0);
        chk("rst_err_oob", err_oob2, 0);
        chk("rst_err_addr", err_addr2, 0);
        chk("rst_outstanding", outst2, 0);
        rst = 1'b0;

        // Write then read next cycle
        drive_wr(32'h10, 32'h1122_3344, 4'hF);
        tick();
        chk("wr_rd_c1_en", resp_en2, 0);
        chk("wr_rd_c1_out", outst2, 1);
        drive_rd(32'h10);
        tick();
        request_enable = 1'b0;
        chk("wr_rd_c2_en", resp_en2, 1);
        chk("wr_rd_c2_data", resp_data2, 32'h0);
        chk("wr_rd_c2_out", outst2, 2);
        tick();
        chk("wr_rd_c3_en", resp_en2, 1);
        chk("wr_rd_c3_data", resp_data2, 32'h1122_3344);
        chk("wr_rd_c3_out", outst2, 1);
        tick();
        chk("wr_rd_c4_en", resp_en2, 0);
        chk("wr_rd_c4_hold", resp_data2, 32'h1122_3344);
        chk("wr_rd_c4_out", outst2, 0);

        // Partial writes
        wr(32'h20, 32'hAABB_CCDD, 4'hF);
        wr(32'h20, 32'h0000_1200, 4'b0010);
        rd_expect("partial", 32'h20, 32'hAABB_12DD);
        wr(32'h20, 32'hFFFF_FFFF, 4'b0000);
        rd_expect("no_strb", 32'h20, 32'hAABB_12DD);

        // Stream of back-to-back reads
        for (int i = 0; i < 8; i++) wr(32'(4 * i), pre[i], 4'hF);
        pulses = 0;
        first = -1;
        last = -1;
        maxo = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc < 8) begin
                drive_rd(32'(4 * cyc));
                exp_q.push_back(pre[cyc]);
            end else begin
                request_enable = 1'b0;
            end
            tick();
            if (int'(outst2) > maxo) maxo = int'(outst2);
            if (resp_en2 === 1'b1) begin
                if (exp_q.size() > 0) chk("stream_data", resp_data2, exp_q.pop_front());
                if (first < 0) first = cyc;
                last = cyc;
                pulses++;
            end
        end
        chk("stream_pulses", pulses, 8);
        chk("stream_contig", last - first, 7);
        chk("stream_peak", maxo, 2);
        chk("stream_out_end", outst2, 0);
        chk("stream_q_empty", exp_q.size(), 0);

        // Out-of-range accesses, first fault wins
        rd_expect("oob_rd1", 32'h0000_4000, 32'hDEAD_BEEF);
        chk("oob1_flag", err_oob2, 1);
        chk("oob1_addr", err_addr2, 32'h0000_4000);
        rd_expect("oob_rd2", 32'h8000_0000, 32'hDEAD_BEEF);
        chk("oob2_addr", err_addr2, 32'h0000_4000);
        drive_wr(32'h0000_4000, 32'h1234_5678, 4'hF);
        tick();
        request_enable = 1'b0;
        tick();
        chk("oob_wr_en", resp_en2, 1);
        chk("oob_wr_data", resp_data2, 32'hDEAD_BEEF);
        tick();
        rd_expect("oob_no_alias", 32'h0, pre[0]);
        chk("oob_sticky_flag", err_oob2, 1);
        chk("oob_sticky_addr", err_addr2, 32'h0000_4000);

        // Reset mid-flight; request during reset is ignored
        flush();
        drive_rd(32'h4);
        tick();
        rst = 1'b1;
        drive_wr(32'h0, 32'hFFFF_FFFF, 4'hF);
        tick();
        rst = 1'b0;
        request_enable = 1'b0;
        pulses = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (resp_en2 === 1'b1) pulses++;
            if (resp_en8 === 1'b1) pulses++;
            tick();
        end
        chk("midrst_pulses", pulses, 0);
        chk("midrst_out2", outst2, 0);
        chk("midrst_out8", outst8, 0);
        chk("midrst_err_oob", err_oob2, 0);
        chk("midrst_err_addr", err_addr2, 0);
        rd_expect("midrst_ram_kept", 32'h0, pre[0]);

        // Latency of the 1, 2 and 8 builds
        flush();
        lat1 = 0; lat2 = 0; lat8 = 0;
        d1 = 32'h0; d2 = 32'h0; d8 = 32'h0;
        drive_rd(32'h4);
        tick();
        request_enable = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (resp_en1 === 1'b1 && lat1 == 0) begin lat1 = cyc; d1 = resp_data1; end
            if (resp_en2 === 1'b1 && lat2 == 0) begin lat2 = cyc; d2 = resp_data2; end
            if (resp_en8 === 1'b1 && lat8 == 0) begin lat8 = cyc; d8 = resp_data8; end
            tick();
        end
        chk("lat1_cycles", lat1, 1);
        chk("lat1_data", d1, pre[1]);
        chk("lat2_cycles", lat2, 2);
        chk("lat2_data", d2, pre[1]);
        chk("lat8_cycles", lat8, 8);
        chk("lat8_data", d8, pre[1]);
        chk("lat8_out_end", outst8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the core's fetch/memory request interface. Receives one-cycle request pulses (mode, addr, wdata, wstrb) from the initiator and returns a one-cycle response pulse with read data after a fixed latency.
- Backed by an internal byte-writable word RAM.
- Used both as the fetch-port target and as the data-port target in simulation and FPGA bring-up.
- Fully pipelined: accepts one request per cycle and needs no ready signal.

Parameters:
- ADDR_WIDTH, 12, number of word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from accepted request to response pulse; legal values 1..8.
- FAULT_DATA, 32'hDEADBEEF, resp_data returned for out-of-range accesses.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- request_enable  in  1  one-cycle pulse, request valid this cycle
- req_mode  in  1  0 = read, 1 = write
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  write data, little-endian byte lanes
- req_wstrb  in  4  byte enables; bit i writes bits [8i+7:8i]
- response_enable  out  1  one-cycle pulse, response valid
- resp_data  out  32  read data (0 for writes, FAULT_DATA on fault)
- err_oob  out  1  sticky flag: an out-of-range request has been seen
- err_addr  out  32  req_addr of the first out-of-range request
- outstanding  out  4  number of requests accepted but not yet responded

Behaviour:
- Reset (clk edge with rst=1): response_enable=0, resp_data=0, err_oob=0, err_addr=0, outstanding=0; all pipeline valid bits cleared. RAM contents are not reset and are preserved.
- Reset mid-operation: all in-flight responses are dropped, with no pulse after reset deasserts. A request presented in the same cycle as rst=1 is ignored, and no RAM write occurs.
- Acceptance: every cycle with request_enable=1 and rst=0 accepts the request. There is no backpressure.
- Word index = req_addr[ADDR_WIDTH+1:2]. The request is out-of-range if req_addr[31:ADDR_WIDTH+2] != 0.
- Write, in range: RAM is updated at the acceptance edge for the lanes with req_wstrb=1. wstrb=4'b0000 changes nothing but still produces a response. Response data is 32'h0.
- Read, in range: RAM is read at the acceptance edge. A read issued in the cycle after a write to the same word returns the new data. A write and read cannot share a cycle (one request per cycle). req_wstrb and req_wdata are ignored.
- Out-of-range: no RAM access; the response carries FAULT_DATA for both modes. err_oob is set. err_addr captures req_addr only if err_oob was 0 before this request (first fault wins). Both are held until reset.
- Latency: request sampled at edge t produces response_enable=1 for exactly the cycle after edge t+LATENCY-1 (i.e. LATENCY cycles later). resp_data is valid only while response_enable=1 and holds its last value otherwise.
- Ordering: responses are strictly in order. Back-to-back requests yield back-to-back response pulses.
- Pipeline: LATENCY-stage shift register of {valid, fault, is_write, data}; stage 0 is loaded at the acceptance edge.
- outstanding: +1 on acceptance, -1 on a response pulse, unchanged when both occur in the same cycle. Maximum value is LATENCY, so no overflow is possible.

Decomposition:
- Package mem_responder_pkg holds MODE_READ = 1'b0, MODE_WRITE = 1'b1, the default FAULT_DATA, and the pipeline-stage struct typedef {valid, fault, is_write, data[31:0]}.
- One sub-module, mem_responder_ram: single-port synchronous RAM, 2**ADDR_WIDTH x 32, 4 byte-write enables, registered read, no reset.
  - Its 1-cycle read is stage 0 of the LATENCY pipeline.

Test Plan:
- Write then read, LATENCY=2: write addr 0x10, wdata 0x11223344, wstrb 4'hF at cycle 0; read 0x10 at cycle 1.
  - Response pulses at cycles 2 and 3 with resp_data 0x0 and 0x11223344.
- Partial write: pre-load 0xAABBCCDD at 0x20; write wdata 0x00001200, wstrb 4'b0010; read 0x20 -> 0xAABB12DD. With wstrb 4'b0000 the read returns unchanged data.
- Out-of-range read at 0x0000_4000 (ADDR_WIDTH=12) followed by a fault at 0x8000_0000.
  - Both responses carry 0xDEADBEEF.
  - err_oob=1, err_addr=0x0000_4000, and both stay that way until rst.
- Stream of 8 back-to-back reads of 0x0, 0x4, ..., 0x1C.
  - 8 consecutive response pulses in order with the matching data.
  - outstanding peaks at LATENCY and returns to 0.
- Reset mid-flight: issue 2 reads, assert rst for 1 cycle before the responses return.
  - No response_enable pulses afterwards; outstanding=0.
  - A later read returns RAM data written before the reset.
- LATENCY=1 and LATENCY=8 builds: a single read response arrives exactly 1 and 8 cycles after the request edge.
